// File: rtl/sar_seq_if.sv
// Front-end handshake between the digital controller and the SAR sequencer:
// conversion request in, busy/done/result/error out.
interface sar_seq_if #(
  parameter int unsigned NBIT = 9
);
  logic            START;
  logic            BUSY;
  logic            DONE;
  logic            ERR;
  logic [NBIT-1:0] DOUT;

  modport master (
    output START,
    input  BUSY,
    input  DONE,
    input  DOUT,
    input  ERR
  );

  modport slave (
    input  START,
    output BUSY,
    output DONE,
    output DOUT,
    output ERR
  );
endinterface

// File: rtl/sar_seq.sv
// SAR conversion sequencer: tracks, then runs an MSB-first comparator loop,
// strobing one DAC latch per decided bit and reporting the result with DONE.
module sar_seq #(
  parameter int unsigned NBIT        = 9,
  parameter int unsigned SAMPLE_CYC  = 4,
  parameter int unsigned CMP_TIMEOUT = 8
) (
  input  logic            CLK,
  input  logic            RSTB,
  sar_seq_if.slave        fe,
  input  logic            CMP_P,
  input  logic            CMP_N,
  output logic            CKSB,
  output logic            CKC,
  output logic [NBIT-1:0] CF
);

  localparam int unsigned    IW      = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam logic [7:0]     SMP_LD  = 8'(SAMPLE_CYC);
  localparam logic [7:0]     CMP_TO  = 8'(CMP_TIMEOUT);
  localparam logic [IW-1:0]  IDX_MSB = IW'(NBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_COMP,
    S_LATCH,
    S_RSTC,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [7:0]      smp_cnt_q;
  logic [7:0]      cmp_cnt_q;
  logic [IW-1:0]   idx_q;
  logic [NBIT-1:0] shadow_q;
  logic            err_int_q;

  logic            cksb_q;
  logic            ckc_q;
  logic [NBIT-1:0] cf_q;
  logic            busy_q;
  logic [NBIT-1:0] dout_q;
  logic            done_q;
  logic            err_q;

  logic            cmp_valid;
  logic [NBIT-1:0] idx_onehot;

  // Equal comparator outputs (both low or both high) mean no decision yet.
  assign cmp_valid  = CMP_P ^ CMP_N;
  assign idx_onehot = NBIT'(1) << idx_q;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q   <= S_IDLE;
      smp_cnt_q <= '0;
      cmp_cnt_q <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      err_int_q <= 1'b0;
      cksb_q    <= 1'b0;
      ckc_q     <= 1'b0;
      cf_q      <= '0;
      busy_q    <= 1'b0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cf_q   <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (fe.START) begin
            state_q   <= S_SAMPLE;
            smp_cnt_q <= SMP_LD;
            shadow_q  <= '0;
            err_int_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_SAMPLE: begin
          if (smp_cnt_q <= 8'd1) begin
            state_q   <= S_COMP;
            idx_q     <= IDX_MSB;
            cmp_cnt_q <= 8'd1;
            cksb_q    <= 1'b1;
            ckc_q     <= 1'b1;
          end else begin
            smp_cnt_q <= smp_cnt_q - 8'd1;
          end
        end
        S_COMP: begin
          // Cycle 1 is settling; a decision on the last allowed cycle beats the timeout.
          if ((cmp_cnt_q >= 8'd2) && cmp_valid) begin
            shadow_q[idx_q] <= CMP_P;
            cf_q            <= idx_onehot;
            state_q         <= S_LATCH;
          end else if (cmp_cnt_q >= CMP_TO) begin
            shadow_q[idx_q] <= 1'b0;
            err_int_q       <= 1'b1;
            ckc_q           <= 1'b0;
            state_q         <= S_RSTC;
          end else begin
            cmp_cnt_q <= cmp_cnt_q + 8'd1;
          end
        end
        S_LATCH: begin
          ckc_q   <= 1'b0;
          state_q <= S_RSTC;
        end
        S_RSTC: begin
          if (idx_q == '0) begin
            state_q <= S_DONE;
            dout_q  <= shadow_q;
            err_q   <= err_int_q;
            done_q  <= 1'b1;
            cksb_q  <= 1'b0;
          end else begin
            idx_q     <= idx_q - IW'(1);
            cmp_cnt_q <= 8'd1;
            ckc_q     <= 1'b1;
            state_q   <= S_COMP;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CKSB    = cksb_q;
  assign CKC     = ckc_q;
  assign CF      = cf_q;
  assign fe.BUSY = busy_q;
  assign fe.DONE = done_q;
  assign fe.DOUT = dout_q;
  assign fe.ERR  = err_q;

endmodule
